// File: rtl/uart_resp_tx.sv
// Response-framing transmitter: sends cmd, payload[0..len-1], CR, NL through a
// one-byte-at-a-time uart handshake (transmit / tx_byte / is_transmitting).
module uart_resp_tx #(
    parameter int PAYLOAD_BYTES = 8,
    parameter int LEN_BITS      = 4,
    parameter int START_TO      = 64
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [7:0]                 req_cmd,
    input  logic [LEN_BITS-1:0]        req_len,
    input  logic [8*PAYLOAD_BYTES-1:0] req_payload,
    output logic                       transmit,
    output logic [7:0]                 tx_byte,
    input  logic                       is_transmitting,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int IDX_W = $clog2(PAYLOAD_BYTES + 3);
    localparam int CNT_W = (START_TO > 2) ? $clog2(START_TO) : 1;

    typedef enum logic [2:0] {IDLE, DRAIN, SEND, WAIT_HI, WAIT_LO, ADV} state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [IDX_W-1:0]           len_q, len_d;
    logic [7:0]                 cmd_q, cmd_d;
    logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [7:0]                 tx_byte_q, tx_byte_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    // Frame byte idx: 0 is cmd, 1..len payload, len+1 CR, len+2 NL.
    function automatic logic [7:0] frame_byte(
        input logic [IDX_W-1:0]           idx,
        input logic [7:0]                 cmd,
        input logic [IDX_W-1:0]           len,
        input logic [8*PAYLOAD_BYTES-1:0] payload
    );
        logic [7:0] b;
        b = '0;
        if (idx == '0) begin
            b = cmd;
        end else if (idx == len + IDX_W'(1)) begin
            b = 8'h0d;
        end else if (idx == len + IDX_W'(2)) begin
            b = 8'h0a;
        end else begin
            for (int unsigned k = 0; k < PAYLOAD_BYTES; k++) begin
                if (idx == IDX_W'(k + 1)) b = payload[8*k +: 8];
            end
        end
        return b;
    endfunction

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            cmd_q     <= '0;
            payload_q <= '0;
            cnt_q     <= '0;
            tx_byte_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            cmd_q     <= cmd_d;
            payload_q <= payload_d;
            cnt_q     <= cnt_d;
            tx_byte_q <= tx_byte_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        cmd_d     = cmd_q;
        payload_d = payload_q;
        cnt_d     = cnt_q;
        tx_byte_d = tx_byte_q;
        done_d    = 1'b0;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cmd_d     = req_cmd;
                    payload_d = req_payload;
                    if (req_len > LEN_BITS'(PAYLOAD_BYTES)) begin
                        len_d = IDX_W'(PAYLOAD_BYTES);
                        err_d = 1'b1;
                    end else begin
                        len_d = IDX_W'(req_len);
                        err_d = 1'b0;
                    end
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // tx_byte is loaded on entry to SEND so it is already stable with the pulse.
                if (!is_transmitting) begin
                    tx_byte_d = frame_byte(idx_q, cmd_q, len_q, payload_q);
                    state_d   = SEND;
                end
            end
            SEND: begin
                cnt_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (is_transmitting) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == CNT_W'(START_TO - 2)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LO: begin
                if (!is_transmitting) state_d = ADV;
            end
            ADV: begin
                if (idx_q == len_q + IDX_W'(2)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d     = idx_q + IDX_W'(1);
                    tx_byte_d = frame_byte(idx_q + IDX_W'(1), cmd_q, len_q, payload_q);
                    state_d   = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign transmit  = (state_q == SEND);
    assign tx_byte   = tx_byte_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_resp_tx.sv
// Bench for uart_resp_tx: vector table, multi-cycle corner sequences and
// random frames against a byte-queue reference model, with a simple uart model.
module tb_uart_resp_tx;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [3:0]  req_len;
    logic [63:0] req_payload;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        is_transmitting;
    logic        busy;
    logic        done;
    logic        err;

    uart_resp_tx #(.PAYLOAD_BYTES(8), .LEN_BITS(4), .START_TO(64)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_len(req_len), .req_payload(req_payload),
        .transmit(transmit), .tx_byte(tx_byte), .is_transmitting(is_transmitting),
        .busy(busy), .done(done), .err(err)
    );

    always #5 sys_clk = ~sys_clk;

    int cycle = 0;
    always @(posedge sys_clk) cycle++;

    int n_vec  = 0;
    int n_miss = 0;

    // uart model: busy for uart_len cycles starting the cycle after a transmit pulse
    int         uart_len     = 10;
    bit         uart_alive   = 1'b1;
    int         uart_cnt     = 0;
    logic       uart_busy    = 1'b0;
    logic       foreign_busy = 1'b0;
    assign is_transmitting = uart_busy | foreign_busy;

    logic [7:0] cap_q[$];
    int         tx_cnt = 0, done_cnt = 0, first_tx = -1, done_cyc = -1;
    logic       busy_at_done = 1'b1, ready_at_done = 1'b0;

    always @(negedge sys_clk) begin
        if (uart_cnt > 0) begin
            uart_busy = 1'b1;
            uart_cnt--;
        end else begin
            uart_busy = 1'b0;
        end
        if (transmit && uart_alive) uart_cnt = uart_len;
        if (transmit) begin
            cap_q.push_back(tx_byte);
            if (tx_cnt == 0) first_tx = cycle;
            tx_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc      = cycle;
            busy_at_done  = busy;
            ready_at_done = req_ready;
        end
    end

    logic [7:0] exp_q[$];
    bit         exp_err;

    typedef struct {
        logic [7:0]  cmd;
        logic [3:0]  len;
        logic [63:0] pl;
        logic [87:0] exp;     // expected wire bytes, first byte leftmost, NL in [7:0]
        int          exp_n;
        bit          exp_err;
    } vec_t;
    vec_t vecs[7];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic clear_cap();
        cap_q.delete();
        tx_cnt   = 0;
        done_cnt = 0;
        first_tx = -1;
        done_cyc = -1;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_transmit"}, 32'(transmit), 32'd0);
        chk({tag, "_tx_byte"}, 32'(tx_byte), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic do_req(input logic [7:0] cmd, input logic [3:0] len, input logic [63:0] pl,
                          output int acc, output bit ok);
        req_cmd     = cmd;
        req_len     = len;
        req_payload = pl;
        req_valid   = 1'b1;
        ok  = 1'b0;
        acc = -1;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (req_ready) begin
                acc = cycle;
                ok  = 1'b1;
            end
            tick();
        end
        req_valid = 1'b0;
        chk("accept", 32'(ok), 32'd1);
    endtask

    // Reference: clamp the length, then cmd, payload bytes in order, CR, NL.
    task automatic model(input logic [7:0] cmd, input logic [3:0] len, input logic [63:0] pl);
        int n;
        n = (len > 8) ? 8 : int'(len);
        exp_q.delete();
        exp_q.push_back(cmd);
        for (int k = 0; k < n; k++) exp_q.push_back(pl[8*k +: 8]);
        exp_q.push_back(8'h0d);
        exp_q.push_back(8'h0a);
        exp_err = (len > 8);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [3:0] len, input logic [63:0] pl,
                             input int ulen);
        int acc;
        bit ok;
        uart_len = ulen;
        clear_cap();
        do_req(cmd, len, pl, acc, ok);
        chk("err_after_accept", 32'(err), 32'(exp_err));
        wait_done(400);
        tick();
        tick();
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("tx_count", 32'(tx_cnt), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size(); j++)
            chk($sformatf("byte%0d_cmd%02h", j, cmd), (j < cap_q.size()) ? 32'(cap_q[j]) : 32'h1ff,
                32'(exp_q[j]));
        chk("first_tx_latency", 32'(first_tx - acc), 32'd2);
        chk("busy_at_done", 32'(busy_at_done), 32'd0);
        chk("ready_at_done", 32'(ready_at_done), 32'd1);
        chk("tx_byte_hold", 32'(tx_byte), 32'h0a);
        chk("err_after_done", 32'(err), 32'(exp_err));
    endtask

    initial begin
        int acc, fall;
        bit ok;
        req_valid   = 1'b0;
        req_cmd     = '0;
        req_len     = '0;
        req_payload = '0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();
        check_idle_outputs("post_reset");

        vecs[0] = '{8'h02, 4'd4,  64'h0000_0000_0000_1234, 88'h02_34_12_00_00_0d_0a, 7, 1'b0};
        vecs[1] = '{8'h05, 4'd0,  64'hffff_ffff_ffff_ffff, 88'h05_0d_0a, 3, 1'b0};
        vecs[2] = '{8'h04, 4'd15, 64'h8877_6655_4433_2211, 88'h04_11_22_33_44_55_66_77_88_0d_0a, 11, 1'b1};
        vecs[3] = '{8'h09, 4'd1,  64'h0000_0000_0000_00ab, 88'h09_ab_0d_0a, 4, 1'b0};
        vecs[4] = '{8'h10, 4'd8,  64'h0102_0304_0506_0708, 88'h10_08_07_06_05_04_03_02_01_0d_0a, 11, 1'b0};
        vecs[5] = '{8'h0d, 4'd2,  64'h0000_0000_0000_0a0d, 88'h0d_0d_0a_0d_0a, 5, 1'b0};
        vecs[6] = '{8'h11, 4'd9,  64'hf0e0_d0c0_b0a0_9080, 88'h11_80_90_a0_b0_c0_d0_e0_f0_0d_0a, 11, 1'b1};
        for (int r = 0; r < 7; r++) begin
            exp_q.delete();
            for (int j = 0; j < vecs[r].exp_n; j++)
                exp_q.push_back(vecs[r].exp[8*(vecs[r].exp_n-1-j) +: 8]);
            exp_err = vecs[r].exp_err;
            run_frame(vecs[r].cmd, vecs[r].len, vecs[r].pl, 10);
        end

        // Start timeout: uart never raises is_transmitting
        uart_alive = 1'b0;
        clear_cap();
        do_req(8'h07, 4'd2, 64'hbeef, acc, ok);
        wait_done(200);
        repeat (5) tick();
        chk("to_done_delay", 32'(done_cyc - first_tx), 32'd64);
        chk("to_tx_count", 32'(tx_cnt), 32'd1);
        chk("to_done_count", 32'(done_cnt), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        chk("to_idle_ready", 32'(req_ready), 32'd1);
        chk("to_idle_busy", 32'(busy), 32'd0);
        uart_alive = 1'b1;

        // Drain foreign traffic, with a competing request held during the frame
        uart_len = 10;
        clear_cap();
        foreign_busy = 1'b1;
        do_req(8'h33, 4'd1, 64'h44, acc, ok);
        req_cmd   = 8'hee;
        req_len   = 4'd0;
        req_valid = 1'b1;
        for (int k = 0; k < 40 && cycle < acc + 20; k++) begin
            chk("bp_ready_drain", 32'(req_ready), 32'd0);
            tick();
        end
        chk("drain_no_tx", 32'(tx_cnt), 32'd0);
        foreign_busy = 1'b0;
        fall = cycle;
        repeat (3) begin
            chk("bp_ready_send", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = 1'b0;
        wait_done(400);
        repeat (3) tick();
        chk("drain_first_tx", 32'(first_tx - fall), 32'd1);
        chk("drain_tx_count", 32'(tx_cnt), 32'd4);
        chk("drain_done_count", 32'(done_cnt), 32'd1);
        chk("drain_byte0", (cap_q.size() > 0) ? 32'(cap_q[0]) : 32'h1ff, 32'h33);
        chk("drain_byte1", (cap_q.size() > 1) ? 32'(cap_q[1]) : 32'h1ff, 32'h44);
        chk("drain_no_second_accept", 32'(busy), 32'd0);

        // Async reset while byte 3 is in flight
        clear_cap();
        do_req(8'h21, 4'd5, 64'h05_0403_0201, acc, ok);
        for (int k = 0; k < 300 && tx_cnt < 4; k++) tick();
        chk("rst_reached_byte3", 32'(tx_cnt), 32'd4);
        chk("rst_byte3_value", (cap_q.size() > 3) ? 32'(cap_q[3]) : 32'h1ff, 32'h03);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("rst_no_tx_after", 32'(tx_cnt), 32'd4);
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        chk("rst_idle_ready", 32'(req_ready), 32'd1);

        // Random frames against the reference model
        for (int n = 0; n < 24; n++) begin
            logic [7:0]  c;
            logic [3:0]  l;
            logic [63:0] p;
            c = 8'($urandom);
            l = 4'($urandom_range(0, 15));
            p = {$urandom, $urandom};
            model(c, l, p);
            run_frame(c, l, p, int'($urandom_range(1, 12)));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
